// File: rtl/fir_serial_param.sv
// fir_serial_param: time-multiplexed single-MAC FIR filter.
//   Each accepted sample shifts into a TAPS-deep delay line and starts a TAPS-cycle
//   MAC pass, y = sum(c[k] * x[n-k]). The full-precision result is written to yout,
//   with a one-cycle valid pulse. Coefficients can be loaded at runtime while idle.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   en, xin              sample strobe and signed sample
//   ready                comb: an en this cycle will be accepted
//   coef_we/addr/din     coefficient write port (only honoured while idle)
//   ovr_clr              clears the sticky overrun flag
//   yout, valid          signed result (held) and its one-cycle update pulse
//   ovr                  sticky: a sample arrived while busy and was dropped
module fir_serial_param #(
    parameter int DATA_W = 12,
    parameter int COEF_W = 12,
    parameter int TAPS   = 8,
    parameter int OUT_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     en,
    input  logic [DATA_W-1:0]        xin,
    output logic                     ready,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]        coef_din,
    input  logic                     ovr_clr,
    output logic [OUT_W-1:0]         yout,
    output logic                     valid,
    output logic                     ovr
);

    localparam int AW     = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic [AW-1:0] LastTap = AW'(TAPS - 1);

    typedef enum logic {StIdle, StMac} state_e;

    state_e                     state_q, state_d;
    logic [AW-1:0]              k_q, k_d;
    logic signed [OUT_W-1:0]    acc_q, acc_d;
    logic signed [OUT_W-1:0]    yout_q, yout_d;
    logic signed [DATA_W-1:0]   x_q [TAPS];
    logic signed [DATA_W-1:0]   x_d [TAPS];
    logic signed [COEF_W-1:0]   c_q [TAPS];
    logic signed [COEF_W-1:0]   c_d [TAPS];
    logic                       valid_q, valid_d;
    logic                       ovr_q, ovr_d;

    logic                       last_tap;
    logic                       accept;
    logic                       coef_ok;
    logic signed [PROD_W-1:0]   prod;
    logic signed [OUT_W-1:0]    mac_sum;

    assign last_tap = (state_q == StMac) && (k_q == LastTap);
    assign ready    = (state_q == StIdle) || last_tap;
    assign accept   = en && ready;

    assign prod    = x_q[k_q] * c_q[k_q];
    assign mac_sum = acc_q + {{(OUT_W - PROD_W){prod[PROD_W-1]}}, prod};

    // Out-of-range addresses only exist when TAPS is not a power of two.
    generate
        if ((1 << AW) == TAPS) begin : g_addr_pow2
            assign coef_ok = 1'b1;
        end else begin : g_addr_npow2
            assign coef_ok = (int'(coef_addr) < TAPS);
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        yout_d  = yout_q;
        valid_d = 1'b0;
        x_d     = x_q;
        c_d     = c_q;
        // Set wins over clear.
        ovr_d   = (ovr_q && !ovr_clr) || (en && !ready);

        if (state_q == StMac) begin
            acc_d = mac_sum;
            k_d   = k_q + 1'b1;
            if (last_tap) begin
                yout_d  = mac_sum;
                valid_d = 1'b1;
                state_d = StIdle;
            end
        end

        // A sample accepted on the final MAC edge restarts immediately; the result
        // above still uses the pre-shift delay line.
        if (accept) begin
            x_d[0] = $signed(xin);
            for (int i = 1; i < TAPS; i++) begin
                x_d[i] = x_q[i-1];
            end
            acc_d   = '0;
            k_d     = '0;
            state_d = StMac;
        end

        if (coef_we && (state_q == StIdle) && coef_ok) begin
            c_d[coef_addr] = $signed(coef_din);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            k_q     <= '0;
            acc_q   <= '0;
            yout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            yout_q  <= yout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            x_q     <= x_d;
            c_q     <= c_d;
        end
    end

    assign yout  = yout_q;
    assign valid = valid_q;
    assign ovr   = ovr_q;

endmodule
